// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle controller.
// Optional ADDI states are present only when MC_CONTROL_ADDI_EN is defined.
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_ALUWB, S_BEQ, S_JUMP
`ifdef MC_CONTROL_ADDI_EN
    , S_ADDIEX, S_ADDIWB
`endif
  } state_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FN, ALU_NONE} alu_op_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] AC_AND  = 3'b000;
  localparam logic [2:0] AC_OR   = 3'b001;
  localparam logic [2:0] AC_ADD  = 3'b010;
  localparam logic [2:0] AC_SUB  = 3'b110;
  localparam logic [2:0] AC_SLT  = 3'b111;
  localparam logic [2:0] AC_NONE = 3'b000;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;
  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: combinational ALU control decode from alu_op and funct.
module mc_aludec
  import mc_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);
  logic [2:0] w_fn;
  always_comb begin
    case (funct)
      FN_SUB:  w_fn = AC_SUB;
      FN_AND:  w_fn = AC_AND;
      FN_OR:   w_fn = AC_OR;
      FN_SLT:  w_fn = AC_SLT;
      default: w_fn = AC_ADD;
    endcase
    alu_ctrl = alu_op == ALU_ADD ? AC_ADD :
               alu_op == ALU_SUB ? AC_SUB :
               alu_op == ALU_FN  ? w_fn   : AC_NONE;
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS control FSM with Moore outputs and memory-ready stalls.
// Define MC_CONTROL_ADDI_EN to support addi (opcode 001000); otherwise it decodes as illegal.
module mc_control
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic [2:0]         alu_ctrl,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);
  state_t  r_state, w_next;
  logic    r_illegal, w_illegal, w_branch;
  alu_op_t w_alu_op;
  mc_aludec u_aludec (.alu_op(w_alu_op), .funct(funct), .alu_ctrl(alu_ctrl));
  always_comb begin
    w_next = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQ;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      w_next = S_ADDIEX;
`endif
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:  w_next = op == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_ALUWB;
`ifdef MC_CONTROL_ADDI_EN
      S_ADDIEX:  w_next = S_ADDIWB;
`endif
      default:   w_next = S_FETCH;
    endcase
  end
  // Outputs are forced low while rst is held, even though the state already reads FETCH.
  always_comb begin
    {pc_write, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a} = '0;
    alu_src_b = SRCB_REG;
    pc_src = PC_ALU;
    w_branch = 1'b0;
    w_alu_op = ALU_NONE;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          ir_write = mem_ready;
          pc_write = mem_ready;
          alu_src_b = SRCB_FOUR;
          w_alu_op = ALU_ADD;
        end
        S_DECODE: begin
          alu_src_b = SRCB_BR;
          w_alu_op = ALU_ADD;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          w_alu_op = ALU_ADD;
        end
        S_MEMRD:  iord = 1'b1;
        S_MEMWR:  {iord, mem_write} = 2'b11;
        S_MEMWB:  {mem_to_reg, reg_write} = 2'b11;
        S_RTYPEEX: begin
          alu_src_a = 1'b1;
          w_alu_op = ALU_FN;
        end
        S_ALUWB:  {reg_dst, reg_write} = 2'b11;
        S_BEQ: begin
          alu_src_a = 1'b1;
          w_alu_op = ALU_SUB;
          w_branch = 1'b1;
          pc_src = PC_BR;
        end
`ifdef MC_CONTROL_ADDI_EN
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          w_alu_op = ALU_ADD;
        end
        S_ADDIWB: reg_write = 1'b1;
`endif
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src = PC_JMP;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_illegal <= w_illegal;
    end
  end
  assign pc_en = pc_write | (w_branch & zero);
  assign illegal = r_illegal;
  assign state = STATE_W'(r_state);
endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter STATE_W, default 4, width of the state register and the state debug output.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port op  input  6  instruction opcode, IR[31:26].
REQ-005 SHALL have port funct  input  6  function field, IR[5:0].
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  memory access complete, sampled in memory states.
REQ-008 SHALL have the following Moore outputs: pc_write, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a (each 1 bit); alu_src_b (2 bits) and pc_src (2 bits).
REQ-009 SHALL have port pc_en  output  1  PC enable, equal to pc_write | (branch & zero).
REQ-010 SHALL have port alu_ctrl  output  3  ALU operation code.
REQ-011 SHALL have port illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-012 SHALL have port state  output  STATE_W  current state, for debug.

Function
REQ-013 SHALL implement the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQ, ADDIEX, ADDIWB and JUMP.
REQ-014 FETCH SHALL assert iord=0, ir_write, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00 and pc_write. ir_write and pc_write SHALL be asserted only in the cycle in which mem_ready=1. The FSM SHALL stay in FETCH while mem_ready=0.
REQ-015 DECODE SHALL last exactly one cycle to cover the registered register-file read latency, with alu_src_a=0, alu_src_b=11 and alu_op=add.
REQ-016 DECODE SHALL branch by opcode: lw 100011 or sw 101011 -> MEMADR; 000000 -> RTYPEEX; beq 000100 -> BEQ; addi 001000 -> ADDIEX; j 000010 -> JUMP. Any other opcode SHALL go to FETCH with illegal=1 for one cycle.
REQ-017 MEMADR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=add, then go to MEMRD for lw or MEMWR for sw.
REQ-018 MEMRD SHALL drive iord=1. MEMWR SHALL drive iord=1 with mem_write asserted in every cycle until mem_ready=1. Both states SHALL hold while mem_ready=0.
REQ-019 MEMRD SHALL go to MEMWB on mem_ready=1. MEMWR SHALL go to FETCH on mem_ready=1.
REQ-020 MEMWB SHALL drive reg_dst=0, mem_to_reg=1 and reg_write=1.
REQ-021 RTYPEEX SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=funct. ALUWB SHALL drive reg_dst=1, mem_to_reg=0 and reg_write=1.
REQ-022 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=add. ADDIWB SHALL drive reg_dst=0, mem_to_reg=0 and reg_write=1.
REQ-023 BEQ SHALL drive alu_src_a=1, alu_src_b=00, alu_op=sub, branch=1 and pc_src=01.
REQ-024 JUMP SHALL drive pc_src=10 and pc_write=1.
REQ-025 MEMWB, ALUWB, ADDIWB, BEQ and JUMP SHALL return to FETCH.
REQ-026 reg_write SHALL be high for exactly one cycle per register-writing instruction, and never in any other state.
REQ-027 All control outputs not listed for a state SHALL be 0.
REQ-028 alu_ctrl SHALL decode as follows: add -> 010; sub -> 110. When alu_op=funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.
REQ-029 Instruction latencies SHALL be, with zero memory wait: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each mem_ready=0 cycle SHALL add one cycle.

Reset
REQ-030 rst=1 SHALL force the FSM to FETCH immediately, including in the middle of a memory wait.
REQ-031 While rst=1, all control outputs and illegal SHALL be 0, and state SHALL read the FETCH encoding.
REQ-032 The first FETCH after reset SHALL begin on the first rising clk edge with rst=0.

Configuration
REQ-033 The macro MC_CONTROL_ADDI_EN SHALL, when defined, enable the ADDIEX and ADDIWB states and the decode of opcode 001000.
REQ-034 When MC_CONTROL_ADDI_EN is undefined, those states SHALL be absent, and opcode 001000 SHALL be treated as illegal (go to FETCH and pulse illegal).

Structure
REQ-035 A package mc_pkg SHALL hold the state enum, opcode localparams, funct localparams, alu_op and alu_ctrl encodings, and the alu_src_b and pc_src encodings.
REQ-036 ALU decoding SHALL be a combinational sub-module, mc_aludec, with inputs alu_op and funct and output alu_ctrl.

Verification
REQ-037 The bench SHALL release rst with mem_ready=1 and op=100011 (lw), and check the state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH with reg_write=1 only in MEMWB.
REQ-038 The bench SHALL run sw with mem_ready held low for 3 cycles in MEMWR, and check that mem_write stays high for 4 cycles, the state holds in MEMWR, and the FSM then goes to FETCH.
REQ-039 The bench SHALL apply R-type with funct=101010, and check alu_ctrl=111 in RTYPEEX, then ALUWB with reg_dst=1 and reg_write=1.
REQ-040 The bench SHALL apply beq twice: with zero=1, pc_en=1 and pc_src=01 in BEQ; with zero=0, pc_en=0 in BEQ.
REQ-041 The bench SHALL apply op=111111 and check a one-cycle illegal pulse after DECODE with a return to FETCH, and shall apply op=001000 with the macro undefined and check the same behaviour.
REQ-042 The bench SHALL assert rst in MEMRD while mem_ready=0, and check that the FSM is in FETCH in the same cycle with all outputs 0.
